// File: rtl/param_datapath.sv
// param_datapath: parametrised RISC datapath (register file, B shifter, ALU, C/status, writeback mux)
// sequenced RD->EX->WB behind a valid/ready handshake. Optional macro DATAPATH_R0_ZERO_EN hardwires R0 to zero.
module param_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(NREGS)-1:0] ra,
  input  logic [$clog2(NREGS)-1:0] rb,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [1:0]               shift,
  input  logic                     asel,
  input  logic                     bsel,
  input  logic [1:0]               alu_op,
  input  logic                     loads,
  input  logic [1:0]               vsel,
  input  logic                     wen,
  input  logic [WIDTH-1:0]         mdata,
  input  logic [WIDTH-1:0]         sximm5,
  input  logic [WIDTH-1:0]         sximm8,
  input  logic [WIDTH-1:0]         pc,
  output logic                     done,
  output logic [2:0]               status,
  output logic [WIDTH-1:0]         datapath_out
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_EX = 2'd2, S_WB = 2'd3} state_t;

  state_t           state_r, state_nxt_s;
  logic [AW-1:0]    ra_r, rb_r, rd_r;
  logic [1:0]       shift_r, alu_op_r, vsel_r;
  logic             asel_r, bsel_r, loads_r, wen_r;
  logic [WIDTH-1:0] sximm5_r;
  logic [WIDTH-1:0] regs_r [NREGS];
  logic [WIDTH-1:0] a_r, b_r, c_r;
  logic [2:0]       status_r;
  logic             done_r;
  logic             accept_s, wr_en_s, alu_v_s;
  logic [WIDTH-1:0] rd_a_s, rd_b_s, b_shift_s, ain_s, bin_s, alu_c_s, wb_val_s;

  // Ready is forced low while reset is asserted, so it cannot be a pure register.
  assign req_ready    = reset_n && (state_r == S_IDLE);
  assign accept_s     = req_valid && req_ready;
  assign done         = done_r;
  assign status       = status_r;
  assign datapath_out = c_r;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= S_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Next-state logic: fixed RD->EX->WB walk once a request is accepted.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:  if (accept_s) state_nxt_s = S_RD; else state_nxt_s = S_IDLE;
      S_RD:    state_nxt_s = S_EX;
      S_EX:    state_nxt_s = S_WB;
      S_WB:    state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Command register: request fields captured at accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ra_r <= '0; rb_r <= '0; rd_r <= '0; shift_r <= 2'b00; alu_op_r <= 2'b00; vsel_r <= 2'b00;
      asel_r <= 1'b0; bsel_r <= 1'b0; loads_r <= 1'b0; wen_r <= 1'b0; sximm5_r <= '0;
    end else if (accept_s) begin
      ra_r <= ra; rb_r <= rb; rd_r <= rd; shift_r <= shift; alu_op_r <= alu_op; vsel_r <= vsel;
      asel_r <= asel; bsel_r <= bsel; loads_r <= loads; wen_r <= wen; sximm5_r <= sximm5;
    end
  end

  // Register-file read ports and write-enable qualification.
  always_comb begin
    rd_a_s  = regs_r[ra_r];
    rd_b_s  = regs_r[rb_r];
    wr_en_s = wen_r;
`ifdef DATAPATH_R0_ZERO_EN
    if (ra_r == {AW{1'b0}}) rd_a_s = {WIDTH{1'b0}}; else rd_a_s = regs_r[ra_r];
    if (rb_r == {AW{1'b0}}) rd_b_s = {WIDTH{1'b0}}; else rd_b_s = regs_r[rb_r];
    if (rd_r == {AW{1'b0}}) wr_en_s = 1'b0; else wr_en_s = wen_r;
`endif
  end

  // B shifter and operand selection; the immediate bypasses the shifter.
  always_comb begin
    b_shift_s = b_r;
    case (shift_r)
      2'b00:   b_shift_s = b_r;
      2'b01:   b_shift_s = {b_r[WIDTH-2:0], 1'b0};
      2'b10:   b_shift_s = {1'b0, b_r[WIDTH-1:1]};
      2'b11:   b_shift_s = {b_r[WIDTH-1], b_r[WIDTH-1:1]};
      default: b_shift_s = b_r;
    endcase
    if (asel_r) ain_s = {WIDTH{1'b0}}; else ain_s = a_r;
    if (bsel_r) bin_s = sximm5_r;      else bin_s = b_shift_s;
  end

  // ALU; V flags two's-complement overflow for add/sub only.
  always_comb begin
    alu_c_s = {WIDTH{1'b0}};
    alu_v_s = 1'b0;
    case (alu_op_r)
      2'b00: begin
        alu_c_s = ain_s + bin_s;
        alu_v_s = (ain_s[WIDTH-1] == bin_s[WIDTH-1]) && (alu_c_s[WIDTH-1] != ain_s[WIDTH-1]);
      end
      2'b01: begin
        alu_c_s = ain_s - bin_s;
        alu_v_s = (ain_s[WIDTH-1] != bin_s[WIDTH-1]) && (alu_c_s[WIDTH-1] != ain_s[WIDTH-1]);
      end
      2'b10:   alu_c_s = ain_s & bin_s;
      2'b11:   alu_c_s = ~bin_s;
      default: alu_c_s = {WIDTH{1'b0}};
    endcase
  end

  // Writeback source mux; mdata/sximm8/pc are live inputs at the WB edge.
  always_comb begin
    wb_val_s = c_r;
    case (vsel_r)
      2'b00:   wb_val_s = c_r;
      2'b01:   wb_val_s = mdata;
      2'b10:   wb_val_s = sximm8;
      2'b11:   wb_val_s = pc;
      default: wb_val_s = c_r;
    endcase
  end

  // Pipeline registers A/B/C, status flags and the done pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_r <= '0; b_r <= '0; c_r <= '0; status_r <= 3'b000; done_r <= 1'b0;
    end else begin
      done_r <= (state_r == S_WB);
      if (state_r == S_RD) begin
        a_r <= rd_a_s;
        b_r <= rd_b_s;
      end
      if (state_r == S_EX) begin
        c_r <= alu_c_s;
        if (loads_r) status_r <= {alu_v_s, alu_c_s[WIDTH-1], (alu_c_s == {WIDTH{1'b0}})};
      end
    end
  end

  // Register file; cleared by reset so an aborted op leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_r[i] <= '0;
    end else if ((state_r == S_WB) && wr_en_s) begin
      regs_r[rd_r] <= wb_val_s;
    end
  end
endmodule
